// File: rtl/ks_pluck_exciter_if.sv
// Sample-strobe/trigger bus between a pluck exciter and its controller.
// master drives strobe, trigger and burst settings; slave returns sample and status.
interface ks_pluck_exciter_if #(
  parameter int datawidth = 16,
  parameter int lenbits   = 12,
  parameter int ampbits   = 8
);
  logic                 ena;
  logic                 trigger;
  logic [lenbits-1:0]   length;
  logic [ampbits-1:0]   amplitude;
  logic [datawidth-1:0] q;
  logic                 busy;
  logic                 done;

  modport master (output ena, trigger, length, amplitude, input q, busy, done);
  modport slave  (input ena, trigger, length, amplitude, output q, busy, done);
endinterface

// File: rtl/ks_pluck_exciter.sv
// Karplus-Strong pluck exciter: LFSR noise burst scaled by a latched gain.
// Define KS_EXCITE_ENVELOPE_EN to make the gain decay linearly over the burst.
module ks_pluck_exciter #(
  parameter int datawidth = 16,
  parameter int lenbits   = 12,
  parameter int ampbits   = 8,
  parameter int envshift  = 4
) (
  input logic clk,
  input logic reset,
  ks_pluck_exciter_if.slave bus
);
  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t                       r_state, w_state_nxt;
  logic [23:0]                  r_lfsr;
  logic [lenbits-1:0]           r_cnt;
  logic [ampbits-1:0]           r_gain;
  logic [datawidth-1:0]         r_q;
  logic                         r_busy, r_done;

  logic                         w_load, w_step, w_finish;
  logic [23:0]                  w_lfsr_nxt;
  logic signed [datawidth-1:0]  w_noise;
  logic signed [datawidth+ampbits:0] w_prod, w_shift;
  logic [datawidth-1:0]         w_sample;

  // Galois form of x^24+x^23+x^22+x^17+1, shifting towards the MSB
  assign w_lfsr_nxt = {r_lfsr[22:0], 1'b0} ^ (r_lfsr[23] ? 24'hC20001 : 24'h000000);
  assign w_noise    = r_lfsr[23 -: datawidth];
  assign w_prod     = w_noise * $signed({1'b0, r_gain});
  assign w_shift    = w_prod >>> ampbits;
  assign w_sample   = w_shift[datawidth-1:0];

  // A zero-length trigger is ignored in both states
  assign w_load = bus.trigger && (bus.length != '0);

  always_comb begin
    w_state_nxt = r_state;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE:  if (w_load) w_state_nxt = S_BURST;
      S_BURST: if (!w_load && bus.ena) begin
        if (r_cnt != '0) w_step = 1'b1;
        else begin
          w_finish    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= 24'h000001;
      r_cnt  <= '0;
      r_q    <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_finish;
      // Free-running on every strobe so consecutive plucks differ
      if (bus.ena) r_lfsr <= w_lfsr_nxt;
      if (w_load) begin
        r_cnt  <= bus.length;
        r_busy <= 1'b1;
      end else if (w_step) begin
        r_q   <= w_sample;
        r_cnt <= r_cnt - 1'b1;
      end else if (w_finish) begin
        r_q    <= '0;
        r_busy <= 1'b0;
      end
    end
  end

`ifdef KS_EXCITE_ENVELOPE_EN
  localparam int PW = (envshift > 0) ? envshift : 1;
  logic [PW-1:0] r_pre;
  logic          w_wrap;

  assign w_wrap = (r_pre == PW'((1 << envshift) - 1));

  // Sample uses the current env; the decrement takes effect from the next sample
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gain <= '0;
      r_pre  <= '0;
    end else if (w_load) begin
      r_gain <= bus.amplitude;
      r_pre  <= '0;
    end else if (w_step) begin
      r_pre <= w_wrap ? '0 : r_pre + 1'b1;
      if (w_wrap && r_gain != '0) r_gain <= r_gain - 1'b1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset)       r_gain <= '0;
    else if (w_load) r_gain <= bus.amplitude;
  end
`endif

  assign bus.q    = r_q;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
endmodule

// File: tb/tb_ks_pluck_exciter.sv
// Scoreboard bench for ks_pluck_exciter: directed bursts, retrigger, reset abort, envelope.
module tb_ks_pluck_exciter;
  localparam int DW = 16, LB = 12, AB = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ks_pluck_exciter_if #(.datawidth(DW), .lenbits(LB), .ampbits(AB)) ifc();
  ks_pluck_exciter #(.datawidth(DW), .lenbits(LB), .ampbits(AB), .envshift(0)) dut (
    .clk(clk), .reset(rst), .bus(ifc)
  );

  typedef struct packed {
    logic [DW-1:0] q;
    logic          busy;
    logic          done;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0, failures = 0, done_cnt = 0;
  logic [23:0] m_lfsr = 24'h000001;
  logic [DW-1:0] m_q = '0;

  function automatic logic [23:0] lfsr_next(input logic [23:0] l);
    logic [23:0] s;
    s = l << 1;
    if (l[23]) s = s ^ 24'hC20001;
    return s;
  endfunction

  function automatic logic [DW-1:0] scale(input logic [23:0] l, input int g);
    logic [DW-1:0] nz;
    longint        n;
    nz = l[23:8];
    n  = longint'($signed(nz));
    n  = (n * g) >>> 8;
    return n[DW-1:0];
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) if (ifc.done === 1'b1) done_cnt++;

  // Monitor: every strobe consumes one scoreboard entry
  always @(posedge clk) begin : mon
    exp_t e;
    if (ifc.ena && !rst) begin
      #1;
      if (sbq.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard_empty: got strobe expected none");
      end else begin
        e = sbq.pop_front();
        check("strobe_q", 32'(ifc.q), 32'(e.q));
        check("strobe_busy", 32'(ifc.busy), 32'(e.busy));
        check("strobe_done", 32'(ifc.done), 32'(e.done));
      end
    end
  end

  task automatic pulse(input bit with_trig, input int len, input int amp);
    @(negedge clk);
    ifc.ena = 1'b1;
    if (with_trig) begin
      ifc.trigger = 1'b1; ifc.length = LB'(len); ifc.amplitude = AB'(amp);
    end
    @(negedge clk);
    ifc.ena = 1'b0; ifc.trigger = 1'b0;
    m_lfsr = lfsr_next(m_lfsr);
    repeat (6) @(negedge clk);
  endtask

  task automatic strobe_s(input int g);
    exp_t e;
    e = '{q: scale(m_lfsr, g), busy: 1'b1, done: 1'b0};
    m_q = e.q;
    sbq.push_back(e);
    pulse(0, 0, 0);
  endtask

  task automatic strobe_end();
    sbq.push_back('{q: '0, busy: 1'b0, done: 1'b1});
    m_q = '0;
    pulse(0, 0, 0);
  endtask

  task automatic strobe_hold(input bit b);
    sbq.push_back('{q: m_q, busy: b, done: 1'b0});
    pulse(0, 0, 0);
  endtask

  task automatic strobe_retrig(input int len, input int amp);
    sbq.push_back('{q: m_q, busy: 1'b1, done: 1'b0});
    pulse(1, len, amp);
  endtask

  task automatic trig(input int len, input int amp);
    @(negedge clk);
    ifc.trigger = 1'b1; ifc.length = LB'(len); ifc.amplitude = AB'(amp);
    @(negedge clk);
    ifc.trigger = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ifc.ena = 1'b0; ifc.trigger = 1'b0; ifc.length = '0; ifc.amplitude = '0;
    repeat (3) @(negedge clk);
    check("reset_q", 32'(ifc.q), 0);
    check("reset_busy", 32'(ifc.busy), 0);
    check("reset_done", 32'(ifc.done), 0);
    rst = 1'b0;

    // 1: four full-scale samples then a zero and done
    trig(4, 255);
    check("t1_busy_rise", 32'(ifc.busy), 1);
    for (int i = 0; i < 4; i++) strobe_s(255);
    strobe_end();
    check("t1_done_cnt", done_cnt, 1);

    // 2: zero amplitude gives silent burst
    trig(10, 0);
    for (int i = 0; i < 10; i++) strobe_s(0);
    strobe_end();
    check("t2_done_cnt", done_cnt, 2);

    // 3: zero-length trigger ignored, LFSR keeps running
    trig(0, 77);
    check("t3_busy", 32'(ifc.busy), 0);
    strobe_hold(0);
    strobe_hold(0);
    check("t3_done_cnt", done_cnt, 2);

    // 4: retrigger on strobe 50 coincident with ena
    trig(100, 255);
    for (int i = 0; i < 49; i++) strobe_s(255);
    strobe_retrig(3, 64);
    for (int i = 0; i < 3; i++) strobe_s(64);
    strobe_end();
    check("t4_done_cnt", done_cnt, 3);

    // 5: reset mid-burst
    trig(8, 255);
    strobe_s(255);
    strobe_s(255);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("t5_q", 32'(ifc.q), 0);
    check("t5_busy", 32'(ifc.busy), 0);
    check("t5_done", 32'(ifc.done), 0);
    rst = 1'b0;
    m_lfsr = 24'h000001; m_q = '0;
    repeat (3) @(negedge clk);
    check("t5_done_cnt", done_cnt, 3);

    // 6: envelope decay (or constant gain), zero-length retrigger ignored
    trig(6, 3);
`ifdef KS_EXCITE_ENVELOPE_EN
    strobe_s(3); strobe_s(2);
    trig(0, 200);
    check("t6_busy_hold", 32'(ifc.busy), 1);
    strobe_s(1); strobe_s(0); strobe_s(0); strobe_s(0);
`else
    strobe_s(3); strobe_s(3);
    trig(0, 200);
    check("t6_busy_hold", 32'(ifc.busy), 1);
    for (int i = 0; i < 4; i++) strobe_s(3);
`endif
    strobe_end();
    check("t6_done_cnt", done_cnt, 4);
    check("sb_drained", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
